// File: rtl/psum_accumulator.sv
// psum_accumulator: accumulates the PE column's 32-bit partial-sum stream over
// NUM_CHANNELS input-channel passes into a per-pixel buffer and emits finished
// output-feature-map pixels with their address.
// Optional feature: define PSUM_RELU_EN to clamp negative final sums to zero.
module psum_accumulator #(
    parameter int unsigned OFMAP_SIZE   = 16,
    parameter int unsigned NUM_CHANNELS = 4,
    parameter int unsigned ADDR_W       = $clog2(OFMAP_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              psum_valid,
    input  logic [31:0]       psum_data,
    output logic              psum_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_data,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              overflow
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CHAN_W = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        FLUSH = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [ADDR_W-1:0] pix_cnt;
    logic [CHAN_W-1:0] chan_cnt;
    logic [DATA_W-1:0] pix_buf [OFMAP_SIZE];

    logic              first_chan;
    logic              last_chan;
    logic              last_pix;
    logic              xfer;
    logic              out_xfer;
    logic [DATA_W-1:0] addend;
    logic [DATA_W-1:0] sum;
    logic [DATA_W-1:0] result;
    logic              sum_ovf;

    // Pass/pixel position decode, handshakes and the accumulate adder
    always_comb begin
        first_chan = (chan_cnt == '0);
        last_chan  = (chan_cnt == CHAN_W'(NUM_CHANNELS - 1));
        last_pix   = (pix_cnt == ADDR_W'(OFMAP_SIZE - 1));
        // Final pass may only accept when the output register is free or draining
        psum_ready = (state == ACCUM) && (!last_chan || !out_valid || out_ready);
        xfer       = psum_valid && psum_ready;
        out_xfer   = out_valid && out_ready;
        // Channel 0 ignores stale buffer contents by adding to zero
        addend     = first_chan ? '0 : pix_buf[pix_cnt];
        sum        = addend + psum_data;
        sum_ovf    = (addend[DATA_W-1] == psum_data[DATA_W-1]) &&
                     (sum[DATA_W-1] != addend[DATA_W-1]);
`ifdef PSUM_RELU_EN
        result     = sum[DATA_W-1] ? '0 : sum;
`else
        result     = sum;
`endif
    end

    // Next-state logic; FLUSH lingers through the done cycle so a coincident start is ignored
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) state_next = ACCUM;
            end
            ACCUM: begin
                if (xfer && last_chan && last_pix) state_next = FLUSH;
            end
            FLUSH: begin
                if (done) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // State register plus busy/done status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state_next != IDLE);
            done  <= (state == FLUSH) && out_xfer;
        end
    end

    // Pixel/channel counters and sticky overflow flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_cnt  <= '0;
            chan_cnt <= '0;
            overflow <= 1'b0;
        end else if ((state == IDLE) && start) begin
            pix_cnt  <= '0;
            chan_cnt <= '0;
            overflow <= 1'b0;
        end else if (xfer) begin
            overflow <= overflow | sum_ovf;
            if (last_pix) begin
                pix_cnt  <= '0;
                chan_cnt <= last_chan ? '0 : chan_cnt + CHAN_W'(1);
            end else begin
                pix_cnt  <= pix_cnt + ADDR_W'(1);
            end
        end
    end

    // Output register: loaded by final-pass transfers, cleared once drained
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_addr  <= '0;
        end else if (xfer && last_chan) begin
            out_valid <= 1'b1;
            out_data  <= result;
            out_addr  <= pix_cnt;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Per-pixel partial-sum buffer; the final pass never writes back
    always_ff @(posedge clk) begin
        if (xfer && !last_chan) begin
            pix_buf[pix_cnt] <= sum;
        end
    end

endmodule

// File: doc/psum_accumulator.md
# psum_accumulator

Receiving end of the PE array's partial-sum output: takes the 32-bit `outpsum` stream produced by a convolution PE column, accumulates it across input-channel passes into a per-pixel buffer, and emits finished output-feature-map values with their pixel address. It sits between the PE array and the ofmap writer and is the only sequential stage on the psum path.

## Interface
- `OFMAP_SIZE`, 16: output pixels per channel pass (≥2).
- `NUM_CHANNELS`, 4: input-channel passes summed per pixel (≥1).
- `ADDR_W`, `$clog2(OFMAP_SIZE)`: width of `out_addr`.
- `clk`  in  1  single clock, all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle pulse that begins a new accumulation job; honoured only in IDLE.
- `psum_valid`  in  1  `psum_data` is valid.
- `psum_data`  in  32  signed two's-complement partial sum from the PE column.
- `psum_ready`  out  1  accumulator accepts `psum_data` this cycle.
- `out_valid`  out  1  `out_data`/`out_addr` hold a finished pixel.
- `out_ready`  in  1  downstream accepts the output.
- `out_data`  out  32  finished pixel value, signed.
- `out_addr`  out  ADDR_W  pixel index of `out_data`.
- `busy`  out  1  state is not IDLE.
- `done`  out  1  one-cycle pulse after the job's last output transfers.
- `overflow`  out  1  sticky: a signed overflow occurred during the current job.

## Operation
- States: IDLE, ACCUM, FLUSH.
- IDLE: `psum_ready`=0. `start` → ACCUM. It also clears `pix_cnt`, `chan_cnt` and `overflow`.
- ACCUM: a transfer happens when `psum_valid && psum_ready`. Pixels arrive in order 0..OFMAP_SIZE-1, one full pass per channel.
  - Channel 0: `buf[pix]` ← `psum_data`. Prior contents are ignored.
  - Channels 1..NUM_CHANNELS-2: `buf[pix]` ← `buf[pix] + psum_data`.
  - Last channel: the sum `buf[pix] + psum_data` (or `psum_data` alone when NUM_CHANNELS=1) is loaded into the output register together with `out_addr`=pix. It is not written back to the buffer.
- Counters: `pix_cnt` advances on each transfer and wraps at OFMAP_SIZE-1 → 0. On that wrap, `chan_cnt` increments.
- A transfer on the last pixel of the last channel → FLUSH.
- FLUSH: `psum_ready`=0. Once the pending output transfers (`out_valid && out_ready`), pulse `done` and go to IDLE.
- Arithmetic: 32-bit modulo-2^32 add. Set `overflow` when both operands share a sign and the result's sign differs. `overflow` holds until the next accepted `start` or reset.
- `start` outside IDLE is ignored. `psum_valid` in IDLE or FLUSH is ignored and no data is consumed.

## Timing
- Reset values: `psum_ready`=0, `out_valid`=0, `out_data`=0, `out_addr`=0, `busy`=0, `done`=0, `overflow`=0. State is IDLE and counters are 0. Buffer contents are unspecified; channel 0 overwrites them.
- `busy`=1 from the cycle after `start` until the cycle `done` is high, inclusive.
- Non-final passes: `psum_ready`=1 every ACCUM cycle, giving one psum per cycle.
- Final pass: `psum_ready` = `!out_valid || out_ready`.
  - Output latency is 1 cycle: `out_valid` rises on the edge that accepts the psum.
  - Back-to-back outputs sustain one per cycle while `out_ready`=1.
- `out_valid`, `out_data` and `out_addr` are stable while `out_valid && !out_ready`.
- On the last transfer, `out_valid` drops only on the edge after the handshake. `done` is high for exactly one cycle, on the cycle after that handshake.
- Simultaneous events:
  - In the final pass, an output handshake and a new psum acceptance in the same cycle replace the output register in place; `out_valid` stays 1.
  - `start` on the same cycle as `done`: `start` is ignored, because the state is not yet IDLE.
- Reset asserted mid-job: all state returns immediately to reset values. Any pending output is discarded and `done` does not pulse.

## Configuration
- `PSUM_RELU_EN` defined: the value loaded into `out_data` is clamped to 0 when the final 32-bit sum is negative (bit 31 set). Overflow detection still uses the unclamped sum.
- Not defined: `out_data` is the raw signed sum. There is no ReLU logic.

## Test plan
- Basic job, OFMAP_SIZE=4, NUM_CHANNELS=3, `out_ready`=1:
  - Stimulus: pulse `start`; send pixels 0..3 with values 1,2,3,4 on channel 0, then 10,20,30,40, then 100,200,300,400.
  - Response: outputs (addr,data) = (0,111), (1,222), (2,333), (3,444) on consecutive cycles; `done` 1 cycle after the last output; `overflow`=0.
- Backpressure:
  - Stimulus: as above, but hold `out_ready`=0 for 5 cycles after the first output.
  - Response: `psum_ready`=0 for those cycles; `out_data`=111 and `out_addr`=0 held stable; no psums lost; final sequence identical.
- Overflow:
  - Stimulus: channel 0 sends 0x7FFFFFFF to pixel 0; the next channel sends 1.
  - Response: `out_data`=0x80000000 without the macro, or 0 with `PSUM_RELU_EN`; `overflow`=1 until the next `start`.
- Idle and ignore rules:
  - Stimulus: `psum_valid`=1 in IDLE; `start` during ACCUM.
  - Response: `psum_ready`=0 and no outputs in IDLE; the ongoing job is unaffected by the extra `start`.
- Reset mid-job:
  - Stimulus: deassert `rst_n` during channel 1, then start a fresh job.
  - Response: all outputs go to reset values immediately and `done` never pulses; the fresh job's results are unaffected by stale buffer contents.
